data_mem_responder: RTL

- Data-memory end of the load/store address path: accepts the 8-bit DataAddress produced by the memory-address select logic, plus read/write commands from the control unit, and services them against a 256x8 storage array.
- Uses a valid/ready request channel and a valid/ready read-response channel.
- After reset it runs a zero-fill sweep so that the fixed scratch locations (0, 42, 43, 55-62, 64, 128) start at known values.

---
 rtl/mem_pkg.sv | 13 +
 rtl/data_mem_array.sv | 25 ++
 rtl/data_mem_responder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and fixed scratch addresses for the data-memory path.
package mem_pkg;

  typedef enum logic [1:0] {INIT, IDLE, RESP} mem_state_t;

  localparam int unsigned ADDR_S1       = 42;
  localparam int unsigned ADDR_S2       = 43;
  localparam int unsigned ADDR_LUT_BASE = 55;
  localparam int unsigned ADDR_LUT_END  = 62;
  localparam int unsigned ADDR_HALF     = 64;
  localparam int unsigned ADDR_TOP      = 128;

endpackage

// File: rtl/data_mem_array.sv
// 2**AW x DW storage with a synchronous write port and a registered read port; no reset.
module data_mem_array #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder for the data memory: post-reset zero-fill sweep, then
// valid/ready request and read-response channels against a 2**AW x DW array.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 8,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          ReqValid,
  output logic          ReqReady,
  input  logic          ReqWrite,
  input  logic [AW-1:0] DataAddress,
  input  logic [DW-1:0] DataIn,
  output logic          RespValid,
  input  logic          RespReady,
  output logic [DW-1:0] DataOut,
  output logic          WriteDone,
  output logic          InitBusy
);

  mem_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          resp_valid_q, resp_valid_d;
  logic          write_done_q, write_done_d;
  logic          init_busy_q, init_busy_d;
  logic          has_data_q, has_data_d;

  logic          req_fire;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;

  // A new request is only taken in RESP when the current response drains this cycle.
  assign ReqReady = (state_q == IDLE) || ((state_q == RESP) && RespReady);
  assign req_fire = ReqValid && ReqReady;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    write_done_d = 1'b0;
    init_busy_d  = init_busy_q;
    has_data_d   = has_data_q;
    mem_we       = 1'b0;
    mem_waddr    = DataAddress;
    mem_wdata    = DataIn;
    mem_re       = 1'b0;

    unique case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == '1) begin
          state_d     = IDLE;
          init_busy_d = 1'b0;
        end
      end
      IDLE, RESP: begin
        if (req_fire) begin
          if (ReqWrite) begin
            mem_we       = 1'b1;
            write_done_d = 1'b1;
            resp_valid_d = 1'b0;
            state_d      = IDLE;
          end else begin
            mem_re       = 1'b1;
            has_data_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end
        end else if ((state_q == RESP) && RespReady) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= (INIT_CLEAR != 0) ? INIT : IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      write_done_q <= 1'b0;
      init_busy_q  <= (INIT_CLEAR != 0);
      has_data_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      write_done_q <= write_done_d;
      init_busy_q  <= init_busy_d;
      has_data_q   <= has_data_d;
    end
  end

  data_mem_array #(
    .AW (AW),
    .DW (DW)
  ) u_array (
    .clk_i   (CLK),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (DataAddress),
    .rdata_o (mem_rdata)
  );

  // The read register has no reset, so mask it until the first load lands.
  assign DataOut   = has_data_q ? mem_rdata : '0;
  assign RespValid = resp_valid_q;
  assign WriteDone = write_done_q;
  assign InitBusy  = init_busy_q;

endmodule
